// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Groups the start/done request and result signals of serial_subtractor.
//
//   Handshake: the master raises start with a/b/bin valid. The slave accepts
//   on the rising edge where start=1 and it is not busy. That means it is in
//   IDLE or in the single done cycle. The slave raises busy until the result
//   is ready. It then pulses done for one cycle with diff/bout valid. diff
//   and bout hold their values until a later operation completes. start is
//   ignored while busy; requests are not queued.
//
//   Signals
//     start  master->slave  request
//     a      master->slave  minuend (WIDTH)
//     b      master->slave  subtrahend (WIDTH)
//     bin    master->slave  borrow-in
//     busy   slave->master  bits being processed
//     done   slave->master  one-cycle result-valid pulse
//     diff   slave->master  result (WIDTH)
//     bout   slave->master  final borrow-out / underflow flag
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. It computes diff = a - b - bin modulo
//   2^WIDTH, LSB first, one bit per clock. A single borrow flop carries the
//   borrow between bit positions.
//
//   Parameters
//     WIDTH      operand/result width, 2..32
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (aborts any running op)
//     bus        serial_subtractor_if.slave: start/a/b/bin in,
//                busy/done/diff/bout out
//     dbg_state  current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
//   Timing
//     Accepting edge E0 loads the operands. Bit k is processed at E(k+1).
//     At E(WIDTH) the result is registered and done pulses for one cycle.
//     A start seen during the done cycle is accepted back-to-back.
//
//   Build option
//     SERIAL_SUB_SAT_EN  when defined, an underflowing result (bout=1) is
//                        clamped to zero. bout is still reported as 1.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;

    // One full-subtractor slice on the current LSBs.
    logic             a0, b0;
    logic             bit_d;
    logic             borrow_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign a0         = a_sr_q[0];
    assign b0         = b_sr_q[0];
    assign bit_d      = a0 ^ b0 ^ borrow_q;
    assign borrow_nxt = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
    // Result bits enter at the MSB, so after WIDTH shifts bit 0 is in place.
    assign res_nxt    = {bit_d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    borrow_d = bus.bin;
                    res_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = borrow_nxt;
                res_d    = res_nxt;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = borrow_nxt ? '0 : res_nxt;
`else
                    diff_d  = res_nxt;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            borrow_q <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed testbench for serial_subtractor with WIDTH=8.
//   It applies hand-computed vectors and checks the result, latency and
//   handshake behaviour.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         checks   = 0;
    int         failures = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected diff given the raw modulo result and the underflow flag.
    function automatic logic [7:0] exp_diff(input logic [7:0] raw, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
        return bo ? 8'h00 : raw;
`else
        return raw;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and let the accepting edge E0 happen.
    task automatic start_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic bin);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, ".accept_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".accept_done"}, 32'(bus.done), 32'd0);
        chk({tag, ".accept_state"}, 32'(dbg_state), 32'd1);
    endtask

    // Run edges E1..E8. Done must appear exactly at E8.
    // pulse_at>0 drives a stray start (0xAA - 0x01) just before edge E(pulse_at).
    task automatic finish_op(input string tag, input logic [7:0] ed, input logic ebo,
                             input int pulse_at);
        int busy_cycles;
        busy_cycles = 1;
        for (int i = 1; i < W; i++) begin
            if (i == pulse_at) begin
                bus.a     = 8'hAA;
                bus.b     = 8'h01;
                bus.bin   = 1'b0;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cycles++;
            chk({tag, ".no_early_done"}, 32'(bus.done), 32'd0);
        end
        tick();
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd8);
        chk({tag, ".state_done"}, 32'(dbg_state), 32'd2);
        chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, ".bout"}, 32'(bus.bout), 32'(ebo));
    endtask

    // One complete op followed by a return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] raw, input logic ebo);
        start_op(tag, a, b, bin);
        finish_op(tag, exp_diff(raw, ebo), ebo, 0);
        tick();
        chk({tag, ".done_pulse_end"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"}, 32'(dbg_state), 32'd0);
        chk({tag, ".diff_held"}, 32'(bus.diff), 32'(exp_diff(raw, ebo)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        // Reset state
        #12;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.diff", 32'(bus.diff), 32'd0);
        chk("rst.bout", 32'(bus.bout), 32'd0);
        chk("rst.state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst.idle", 32'(dbg_state), 32'd0);

        // Basic vectors
        run_op("t1_35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        run_op("t2_00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("t3_10m0f_b1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
        run_op("t3_7fm7f_b1", 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1);
        run_op("x_ffm00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_op("x_00m00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op("x_c3m5a", 8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0);

        // A start pulse while busy is ignored, and no second done appears
        start_op("t4", 8'h35, 8'h12, 1'b0);
        finish_op("t4", 8'h23, 1'b0, 3);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t4.no_second_done", 32'(bus.done), 32'd0);
            chk("t4.no_second_busy", 32'(bus.busy), 32'd0);
        end
        chk("t4.diff_kept", 32'(bus.diff), 32'h23);

        // Asynchronous reset in the middle of an op
        start_op("t5", 8'hF0, 8'h0F, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("t5.rst_busy", 32'(bus.busy), 32'd0);
        chk("t5.rst_done", 32'(bus.done), 32'd0);
        chk("t5.rst_diff", 32'(bus.diff), 32'd0);
        chk("t5.rst_bout", 32'(bus.bout), 32'd0);
        chk("t5.rst_state", 32'(dbg_state), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5.after_rst_idle", 32'(dbg_state), 32'd0);
        run_op("t5_09m03", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0);

        // A start held high in the done cycle is accepted back-to-back
        start_op("t6a", 8'h35, 8'h12, 1'b0);
        finish_op("t6a", 8'h23, 1'b0, 0);
        bus.a     = 8'h80;
        bus.b     = 8'h7F;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t6.b2b_busy", 32'(bus.busy), 32'd1);
        chk("t6.b2b_done_fell", 32'(bus.done), 32'd0);
        chk("t6.b2b_state", 32'(dbg_state), 32'd1);
        finish_op("t6b", 8'h01, 1'b0, 0);
        tick();
        chk("t6.idle", 32'(dbg_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
